// File: rtl/cpu_axi_pkg.sv
// cpu_axi_pkg: FSM states and fixed AXI4 field values shared by the CPU-side bus masters.
package cpu_axi_pkg;

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} axi_state_e;

    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/dm_axi_master.sv
// dm_axi_master: turns MEM-stage data requests into single-beat AXI4 reads/writes, stalling via sync_d.
// Optional DM_RESP_ERR_EN adds a sticky bus-error flag with the first failing byte address.
module dm_axi_master
    import cpu_axi_pkg::*;
#(
    parameter int CPU_ADDR_W = 14,
    parameter int AXI_ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W = 4,
    parameter logic [ID_W-1:0] MASTER_ID = 4'd1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dm_req_r,
    input  logic [3:0]            dm_write_en,
    input  logic [CPU_ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0]     dm_data_in,
    output logic [DATA_W-1:0]     dm_data_out,
    output logic                  sync_d,
    output logic [AXI_ADDR_W-1:0] araddr,
    output logic [ID_W-1:0]       arid,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [ID_W-1:0]       rid,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [AXI_ADDR_W-1:0] awaddr,
    output logic [ID_W-1:0]       awid,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [3:0]            wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [ID_W-1:0]       bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
`ifdef DM_RESP_ERR_EN
    ,
    output logic                  dm_err,
    output logic [AXI_ADDR_W-1:0] dm_err_addr
`endif
);

    localparam int PAD_W = AXI_ADDR_W - CPU_ADDR_W - 2;

    axi_state_e state_q, state_d;
    logic [CPU_ADDR_W-1:0] addr_q, addr_d;
    logic [3:0] strb_q, strb_d;
    logic [DATA_W-1:0] wdat_q, wdat_d, data_q, data_d;
    logic arvalid_q, arvalid_d, rready_q, rready_d;
    logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [AXI_ADDR_W-1:0] byte_addr;
    logic unused_ok;

    assign byte_addr = {{PAD_W{1'b0}}, addr_q, 2'b00};
    assign unused_ok = ^{rid, bid, rresp, bresp};

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        strb_d = strb_q;
        wdat_d = wdat_q;
        data_d = data_q;
        arvalid_d = 1'b0;
        rready_d = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d = 1'b0;
        bready_d = 1'b0;
        aw_done_d = aw_done_q;
        w_done_d = w_done_q;
        case (state_q)
            IDLE: begin
                if (dm_req_r | |dm_write_en) begin
                    addr_d = dm_addr;
                    strb_d = dm_write_en;
                    wdat_d = dm_data_in;
                end
                if (|dm_write_en) begin
                    state_d = WR_REQ;
                    awvalid_d = 1'b1;
                    wvalid_d = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d = 1'b0;
                end else if (dm_req_r) begin
                    state_d = RD_ADDR;
                    arvalid_d = 1'b1;
                end
            end
            RD_ADDR: begin
                arvalid_d = ~arready;
                rready_d = arready;
                state_d = arready ? RD_DATA : RD_ADDR;
            end
            RD_DATA: begin
                // beats without rlast are accepted and discarded
                rready_d = ~(rvalid & rlast);
                state_d = (rvalid & rlast) ? DONE : RD_DATA;
                data_d = (rvalid & rlast) ? rdata : data_q;
            end
            WR_REQ: begin
                aw_done_d = aw_done_q | awready;
                w_done_d = w_done_q | wready;
                awvalid_d = ~aw_done_d;
                wvalid_d = ~w_done_d;
                bready_d = aw_done_d & w_done_d;
                state_d = (aw_done_d & w_done_d) ? WR_RESP : WR_REQ;
            end
            WR_RESP: begin
                bready_d = ~bvalid;
                state_d = bvalid ? DONE : WR_RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q <= '0;
            strb_q <= '0;
            wdat_q <= '0;
            data_q <= '0;
            arvalid_q <= 1'b0;
            rready_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q <= 1'b0;
            bready_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            strb_q <= strb_d;
            wdat_q <= wdat_d;
            data_q <= data_d;
            arvalid_q <= arvalid_d;
            rready_q <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q <= wvalid_d;
            bready_q <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q <= w_done_d;
        end
    end

    assign sync_d = ((state_q == IDLE) & (dm_req_r | |dm_write_en)) |
                    (state_q == RD_ADDR) | (state_q == RD_DATA) |
                    (state_q == WR_REQ) | (state_q == WR_RESP);

    assign dm_data_out = data_q;
    assign araddr = byte_addr;
    assign arid = MASTER_ID;
    assign arlen = AXI_LEN_SINGLE;
    assign arsize = AXI_SIZE_WORD;
    assign arburst = AXI_BURST_INCR;
    assign arvalid = arvalid_q;
    assign rready = rready_q;
    assign awaddr = byte_addr;
    assign awid = MASTER_ID;
    assign awlen = AXI_LEN_SINGLE;
    assign awsize = AXI_SIZE_WORD;
    assign awburst = AXI_BURST_INCR;
    assign awvalid = awvalid_q;
    assign wdata = wdat_q;
    assign wstrb = strb_q;
    assign wlast = 1'b1;
    assign wvalid = wvalid_q;
    assign bready = bready_q;

`ifdef DM_RESP_ERR_EN
    logic err_q, err_d, resp_err;
    logic [AXI_ADDR_W-1:0] err_addr_q, err_addr_d;

    assign resp_err = ((state_q == RD_DATA) & rvalid & (rresp != AXI_RESP_OKAY)) |
                      ((state_q == WR_RESP) & bvalid & (bresp != AXI_RESP_OKAY));

    always_comb begin
        err_d = err_q | resp_err;
        err_addr_d = (resp_err & ~err_q) ? byte_addr : err_addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_q <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign dm_err = err_q;
    assign dm_err_addr = err_addr_q;
`endif

endmodule
